// File: rtl/fsm_ab_seq_pkg.sv
// Shared types and sizing helper for the fsm_ab_seq a/b sequence detector.
package fsm_ab_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    FIRE    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  // Counter width able to hold 0..n; never narrower than one bit so n=0 stays legal.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones; sat flags the ceiling.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q;

  assign sat   = &count_q;
  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !sat) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/fsm_ab_seq.sv
// Registered a/b sequence FSM with a-qualification, b-timeout and multi-cycle y.
// Define FSM_AB_SEQ_CNT_EN to build the saturating det_cnt; otherwise det_cnt is 0.
module fsm_ab_seq
  import fsm_ab_seq_pkg::*;
#(
  parameter int unsigned A_COUNT   = 1,
  parameter int unsigned B_TIMEOUT = 0,
  parameter int unsigned Y_HOLD    = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic [1:0]       ps,
  output logic [1:0]       ns,
  output logic             y,
  output logic             timeout,
  output logic [CNT_W-1:0] det_cnt
);

  localparam int unsigned AW = cnt_w_f(A_COUNT);
  localparam int unsigned WW = cnt_w_f(B_TIMEOUT);
  localparam int unsigned HW = cnt_w_f(Y_HOLD);
  localparam bit          TO_EN = (B_TIMEOUT != 0);

  localparam logic [AW-1:0] A_LAST = AW'(A_COUNT - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TO_EN ? B_TIMEOUT - 1 : 0);
  localparam logic [HW-1:0] H_LAST = HW'(Y_HOLD - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] a_run_q, a_run_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_run_q   <= '0;
      wait_q    <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_run_q   <= a_run_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_run_d   = a_run_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      a_run_d = '0;
      wait_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!a) begin
            a_run_d = '0;
          end else if (a_run_q == A_LAST) begin
            state_d = ARM;
            a_run_d = '0;
          end else begin
            a_run_d = a_run_q + AW'(1);
          end
        end
        ARM: begin
          // b wins over an expiring wait in the same cycle
          if (b) begin
            state_d = FIRE;
            wait_d  = '0;
          end else if (TO_EN && wait_q == W_LAST) begin
            state_d   = IDLE;
            wait_d    = '0;
            timeout_d = 1'b1;
          end else if (TO_EN) begin
            wait_d = wait_q + WW'(1);
          end
        end
        FIRE: begin
          if (hold_q == H_LAST) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ps      = state_q;
  assign ns      = state_d;
  assign y       = (state_q == FIRE);
  assign timeout = timeout_q;

`ifdef FSM_AB_SEQ_CNT_EN
  logic det_inc;
  logic det_sat;

  assign det_inc = (state_q == ARM) && b && !clr && !det_sat;

  sat_counter #(.W(CNT_W)) u_det_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (det_inc),
    .count (det_cnt),
    .sat   (det_sat)
  );
`else
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_ab_seq.sv
// Self-checking bench for fsm_ab_seq: default and (3,4,3,W=2) instances share stimulus.
module tb_fsm_ab_seq;
  import fsm_ab_seq_pkg::*;

`ifdef FSM_AB_SEQ_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, a, b;
  logic [1:0] ps0, ns0, ps1, ns1;
  logic       y0, y1, to0, to1;
  logic [7:0] det0;
  logic [1:0] det1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_ab_seq dut0 (
    .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b),
    .ps(ps0), .ns(ns0), .y(y0), .timeout(to0), .det_cnt(det0)
  );

  fsm_ab_seq #(.A_COUNT(3), .B_TIMEOUT(4), .Y_HOLD(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b),
    .ps(ps1), .ns(ns1), .y(y1), .timeout(to1), .det_cnt(det1)
  );

  // Reference: mode 0=waiting for a, 1=waiting for b, 2=holding y.
  typedef struct {
    int mode;
    int streak;
    int waited;
    int held;
    int dets;
    bit to;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.streak = 0; r.waited = 0; r.held = 0; r.dets = 0; r.to = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int ac, int bt, int yh, int cw,
                                 bit c, bit ia, bit ib);
    mdl_t n = m;
    n.to = 1'b0;
    if (c) begin
      n = mdl_reset();
    end else if (m.mode == 0) begin
      if (ia) begin
        n.streak = m.streak + 1;
        if (n.streak >= ac) begin n.mode = 1; n.streak = 0; end
      end else begin
        n.streak = 0;
      end
    end else if (m.mode == 1) begin
      if (ib) begin
        n.mode = 2; n.waited = 0;
        if (m.dets < (1 << cw) - 1) n.dets = m.dets + 1;
      end else if (bt != 0 && m.waited + 1 >= bt) begin
        n.mode = 0; n.waited = 0; n.to = 1'b1;
      end else begin
        n.waited = m.waited + 1;
      end
    end else begin
      n.held = m.held + 1;
      if (n.held >= yh) begin n.mode = 0; n.held = 0; end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ps0", int'(ps0), m0.mode);
    check("y0", int'(y0), int'(m0.mode == 2));
    check("timeout0", int'(to0), int'(m0.to));
    check("det0", int'(det0), CNT_EN ? m0.dets : 0);
    check("ps1", int'(ps1), m1.mode);
    check("y1", int'(y1), int'(m1.mode == 2));
    check("timeout1", int'(to1), int'(m1.to));
    check("det1", int'(det1), CNT_EN ? m1.dets : 0);
  endtask

  task automatic step(input bit c, input bit ia, input bit ib);
    mdl_t n0, n1;
    @(negedge clk);
    clr = c; a = ia; b = ib;
    #1;
    n0 = mstep(m0, 1, 0, 1, 8, c, ia, ib);
    n1 = mstep(m1, 3, 4, 3, 2, c, ia, ib);
    check("ns0", int'(ns0), n0.mode);
    check("ns1", int'(ns1), n1.mode);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
    compare_all();
  endtask

  typedef struct {
    bit c;
    bit a;
    bit b;
    int ps;
    bit y;
    bit to;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // Hand-derived trace for the (A_COUNT=3, B_TIMEOUT=4, Y_HOLD=3) instance.
    tbl[0]  = '{0, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 2, 1, 0};
    tbl[18] = '{0, 1, 1, 2, 1, 0};
    tbl[19] = '{0, 0, 1, 2, 1, 0};
    tbl[20] = '{0, 1, 0, 0, 0, 0};
    tbl[21] = '{0, 1, 0, 0, 0, 0};

    rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("reset ns0", int'(ns0), 0);
    check("reset ns1", int'(ns1), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d ps1", i), int'(ps1), tbl[i].ps);
      check($sformatf("tbl%0d y1", i), int'(y1), int'(tbl[i].y));
      check($sformatf("tbl%0d timeout1", i), int'(to1), int'(tbl[i].to));
    end

    // Default instance: IDLE -a-> ARM -b-> FIRE -> IDLE with one-cycle y.
    step(1, 0, 0);
    step(0, 1, 0);
    check("seq ps0 arm", int'(ps0), 1);
    step(0, 0, 1);
    check("seq ps0 fire", int'(ps0), 2);
    check("seq y0 fire", int'(y0), 1);
    step(0, 0, 0);
    check("seq ps0 idle", int'(ps0), 0);
    check("seq y0 low", int'(y0), 0);
    check("seq det0", int'(det0), CNT_EN ? 1 : 0);

    // Five detections on the 2-bit counter saturate at 3, then clr zeroes it.
    step(1, 0, 0);
    repeat (5) begin
      repeat (3) step(0, 1, 0);
      step(0, 0, 1);
      repeat (3) step(0, 0, 0);
    end
    check("sat det1", int'(det1), CNT_EN ? 3 : 0);
    step(1, 0, 0);
    check("clr det1", int'(det1), 0);
    check("clr ps1", int'(ps1), 0);

    // Asynchronous reset while in FIRE clears outputs before the next edge.
    step(0, 1, 0);
    step(0, 0, 1);
    check("pre-rst ps0", int'(ps0), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ps0", int'(ps0), 0);
    check("async rst y0", int'(y0), 0);
    m0 = mdl_reset();
    m1 = mdl_reset();
    @(negedge clk);
    clr = 1'b0; a = 1'b0; b = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 35);
    end

    // Illegal encoding decodes y=0 and steers back to IDLE.
    step(1, 0, 0);
    @(negedge clk);
    clr = 1'b0; a = 1'b0; b = 1'b0;
    force dut0.state_q = ILLEGAL;
    #1;
    check("illegal ps0", int'(ps0), 3);
    check("illegal y0", int'(y0), 0);
    check("illegal ns0", int'(ns0), 0);
    release dut0.state_q;
    @(posedge clk);
    #1;
    m0 = mstep(m0, 1, 0, 1, 8, 1'b0, 1'b0, 1'b0);
    m1 = mstep(m1, 3, 4, 3, 2, 1'b0, 1'b0, 1'b0);
    compare_all();
    step(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_ab_seq.md
# fsm_ab_seq

Registered, parametrised successor to the team's 3-state a/b sequence FSM. It holds its own state register and adds three things: a qualification count on `a`, a timeout while waiting for `b`, and a multi-cycle `y` pulse. An optional saturating detection counter can be compiled in. The block sits in the same control path as the combinational next-state FSM it replaces, and drives `y` plus state observability to downstream logic and benches.

## Interface
- `A_COUNT`, default 1: consecutive cycles `a` must be high in IDLE to arm; legal range ≥1.
- `B_TIMEOUT`, default 0: maximum cycles spent in ARM waiting for `b`; 0 disables the timeout.
- `Y_HOLD`, default 1: number of cycles `y` stays high per detection; legal range ≥1.
- `CNT_W`, default 8: width of `det_cnt`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear: forces IDLE, zeroes all counters and `det_cnt`.
- `a`  in  1  arm condition.
- `b`  in  1  fire condition.
- `ps`  out  2  current registered state.
- `ns`  out  2  combinational next state.
- `y`  out  1  detection output, high whenever `ps` is FIRE.
- `timeout`  out  1  one-cycle registered pulse on ARM abort.
- `det_cnt`  out  `CNT_W`  saturating count of entries into FIRE.

## Operation
- State encoding:
  - IDLE = 2'b00
  - ARM = 2'b01
  - FIRE = 2'b10
  - 2'b11 is illegal.
- IDLE:
  - `a`=1 increments `a_run`; `a`=0 clears it.
  - When `a`=1 and `a_run`==`A_COUNT`-1, go to ARM and clear `a_run`.
  - `b` is ignored in IDLE.
- ARM:
  - `b`=1 goes to FIRE. `b` has priority over timeout when both occur in the same cycle.
  - Otherwise, if `B_TIMEOUT`≠0 and `wait_cnt`==`B_TIMEOUT`-1, go to IDLE and assert `timeout` in the following cycle.
  - Otherwise `wait_cnt` increments.
  - `a` is ignored in ARM.
  - `wait_cnt` clears on leaving ARM.
- FIRE:
  - `hold_cnt` increments each cycle.
  - When `hold_cnt`==`Y_HOLD`-1, go to IDLE and clear `hold_cnt`.
  - `a` and `b` are ignored; there is no retrigger, so a new detection needs a fresh IDLE qualification.
- Illegal 2'b11: next state is IDLE, `y`=0, and no count changes.
- `y` = (`ps`==FIRE). It is decoded from registered state only and never depends on the inputs (Moore).
- `det_cnt` increments on the ARM→FIRE transition and holds at all-ones.
- `clr` takes priority over all transitions. `rst` takes priority over `clr`.
- Defaults (1,0,1) reproduce the original behaviour: IDLE -a→ ARM -b→ FIRE → IDLE, with ARM waiting indefinitely.

## Timing
- Reset values:
  - `ps`=IDLE
  - `ns`=IDLE when `a`=0, per the IDLE rule above
  - `y`=0, `timeout`=0, `det_cnt`=0
  - all internal counters 0
- Inputs are sampled on rising `clk`.
- Arming latency: `ps` becomes ARM after the `A_COUNT`-th consecutive high `a` sample.
- `y` rises on the edge that samples `b`=1 in ARM, and stays high exactly `Y_HOLD` cycles.
- `timeout` is high for exactly one cycle, coinciding with the first IDLE cycle after the abort.
- Minimum spacing of two detections is `A_COUNT`+1+`Y_HOLD` cycles.
- `rst` asserted mid-operation: outputs go to reset values immediately, without waiting for the clock. Deassertion is taken synchronously by the next edge.

## Configuration
- `FSM_AB_SEQ_CNT_EN` defined: the `det_cnt` register and its increment/saturate logic are built.
- `FSM_AB_SEQ_CNT_EN` undefined: `det_cnt` is tied to 0 and no counter flops are inferred. All other behaviour is identical.

## Structure
- Package `fsm_ab_seq_pkg` holds:
  - `state_e`, the 2-bit enum with IDLE/ARM/FIRE/ILLEGAL
  - a `cnt_w_f(n)` helper sizing internal counters as $clog2(n+1)
- Sub-module `sat_counter`, parametrised on width, with inc/clr/sat ports. It is used for `det_cnt` and reusable elsewhere.
- `a_run`, `wait_cnt` and `hold_cnt` stay inline in the FSM.

## Test plan
- Default parameters, `a`=1 for one cycle then `b`=1 → `ps` goes 00→01→10→00, `y` is high for 1 cycle, `det_cnt`=1.
- `A_COUNT`=3, `a` pattern 1,1,0,1,1,1 → ARM is entered only after the final three highs; `ps` stays 00 until then.
- `B_TIMEOUT`=4, ARM with `b`=0 for 4 cycles → return to IDLE and a one-cycle `timeout`. Repeat with `b`=1 on the 4th ARM cycle → FIRE and no `timeout`.
- `Y_HOLD`=3 → `y` high for exactly 3 cycles; `a` and `b` toggling during FIRE have no effect.
- `CNT_W`=2, 5 detections → `det_cnt` reads 3. Then `clr` → `det_cnt`=0 and `ps`=IDLE.
- `rst` pulse mid-FIRE → `y`=0 and `ps`=00 before the next clock edge. Also force `ps`=11 → IDLE on the next edge with `y`=0.
